// File: rtl/tri_fetch.sv
// Per-frame triangle fetch: walks the face list, gathers three vertices and a
// normal from synchronous memories, and hands each triangle downstream.
module tri_fetch #(
  parameter int NUM_TRIS     = 12,
  parameter int NUM_VERTICES = 8,
  parameter int MEM_LAT      = 2,
  parameter int IDX_W        = $clog2(NUM_VERTICES),
  parameter int FA_W         = (NUM_TRIS > 1) ? $clog2(NUM_TRIS) : 1
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   new_frame_in,
  output logic [FA_W-1:0]        face_addr_out,
  input  logic [4*IDX_W-1:0]     face_data_in,
  output logic [IDX_W-1:0]       vert_addr_out,
  input  logic [95:0]            vert_data_in,
  output logic [3:0][2:0][31:0]  triangle_out,
  output logic                   valid_tri_out,
  input  logic                   tri_ready_in,
  output logic                   obj_done_out,
  output logic                   busy_out,
  output logic                   idx_err_out
);
  typedef enum logic [2:0] {IDLE, FACE_RD, VERT_RD, HOLD, DONE} state_t;

  localparam int CNT_W = $clog2(MEM_LAT + 4) + 1;
  localparam logic [CNT_W-1:0] LAT_C   = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] VEND_C  = CNT_W'(MEM_LAT + 3);
  localparam logic [CNT_W-1:0] THREE_C = CNT_W'(3);
  localparam logic [FA_W-1:0]  LAST_TC = FA_W'(NUM_TRIS - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [FA_W-1:0]         tc_q, tc_d;
  logic [3:0][IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]        vaddr_q, vaddr_d;
  logic [3:0][2:0][31:0]   tri_q, tri_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    err_q, err_d;

  logic [3:0][IDX_W-1:0]   idx_clean;
  logic [3:0]              idx_bad;
  logic [1:0]              ret_slot;

  // Out-of-range indices are forced to vertex 0 so the fetch still completes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_idx
      logic [IDX_W-1:0] raw;
      assign raw            = face_data_in[gi*IDX_W +: IDX_W];
      assign idx_bad[gi]    = (32'(raw) >= 32'(NUM_VERTICES));
      assign idx_clean[gi]  = idx_bad[gi] ? '0 : raw;
    end
  endgenerate

  // Which triangle entry the data arriving this cycle belongs to.
  assign ret_slot = 2'(cnt_q - LAT_C);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tc_d    = tc_q;
    idx_d   = idx_q;
    vaddr_d = vaddr_q;
    tri_d   = tri_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (new_frame_in) begin
          tc_d    = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = FACE_RD;
        end
      end
      FACE_RD: begin
        if (cnt_q == LAT_C) begin
          idx_d   = idx_clean;
          err_d   = err_q | (|idx_bad);
          vaddr_d = idx_clean[0];
          cnt_d   = '0;
          state_d = VERT_RD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      VERT_RD: begin
        if (cnt_q < THREE_C) vaddr_d = idx_q[cnt_q[1:0] + 2'd1];
        if (cnt_q >= LAT_C)  tri_d[ret_slot] = vert_data_in;
        if (cnt_q == VEND_C) begin
          cnt_d   = '0;
          valid_d = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (tri_ready_in) begin
          valid_d = 1'b0;
          if (tc_q == LAST_TC) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            tc_d    = tc_q + 1'b1;
            cnt_d   = '0;
            state_d = FACE_RD;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tc_q    <= '0;
      idx_q   <= '0;
      vaddr_q <= '0;
      tri_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      idx_q   <= idx_d;
      vaddr_q <= vaddr_d;
      tri_q   <= tri_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // The face address is the triangle counter itself; it only moves on accept.
  assign face_addr_out = tc_q;
  assign vert_addr_out = vaddr_q;
  assign triangle_out  = tri_q;
  assign valid_tri_out = valid_q;
  assign obj_done_out  = done_q;
  assign busy_out      = busy_q;
  assign idx_err_out   = err_q;
endmodule
